// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t          : converter FSM states
//   BCD_ADJ_THRESH   : digit value at or above which the add-3 correction applies
//   BCD_ADJ_ADD      : correction added to a digit before each shift
//   min_digits()     : smallest DIGITS able to hold any BIN_W-bit value
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // ceil(bin_w * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so that the following left shift carries correctly into the next digit.
//   digit_in  : 4-bit BCD digit before correction
//   digit_out : corrected digit (4-bit, wraps by design)
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake; in_ready high only while idle
//   in_bin              : unsigned binary value, sampled on the handshake
//   out_valid/out_ready : output handshake; result held until accepted
//   out_bcd             : packed BCD, digit 0 (units) in bits [3:0]
//   out_ovf             : value did not fit in DIGITS decimal digits
//
// state | meaning
// IDLE  | waiting for an input, in_ready high
// SHIFT | adjust digits and shift one binary bit in, BIN_W cycles
// DONE  | result presented on out_bcd/out_ovf until out_ready
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_acc[4*d +: 4]),
      .digit_out (bcd_adj[4*d +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)              state_d = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1))      state_d = DONE;
      DONE:    if (out_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      bcd_acc <= '0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_sr  <= in_bin;
            bcd_acc <= '0;
            ovf_q   <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          // Bit leaving the top digit is a multiple of 10^DIGITS: sticky overflow.
          bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
          ovf_q   <= ovf_q | bcd_adj[BCD_W-1];
          bin_sr  <= bin_sr << 1;
          cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // bcd_acc is frozen outside SHIFT, so the result stays stable under backpressure.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_acc;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: four configurations side by side
// (8b/3 digits, 8b/2 digits, 16b/5 digits, 1b/1 digit).
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic clk;
  logic rst_n;

  logic        in_valid0, in_ready0, out_valid0, out_ready0, ovf0;
  logic [7:0]  bin0;
  logic [11:0] bcd0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
  logic [7:0]  bin1;
  logic [7:0]  bcd1;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
  logic [15:0] bin2;
  logic [19:0] bcd2;
  logic        in_valid3, in_ready3, out_valid3, out_ready3, ovf3;
  logic [0:0]  bin3;
  logic [3:0]  bcd3;

  int errors;
  int checks;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_bin(bin0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_bcd(bcd0), .out_ovf(ovf0));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_bin(bin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_bcd(bcd1), .out_ovf(ovf1));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_bcd(bcd2), .out_ovf(ovf2));

  bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_bin(bin3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_bcd(bcd3), .out_ovf(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] val);
    case (sel)
      0: begin in_valid0 = v; bin0 = val[7:0];  end
      1: begin in_valid1 = v; bin1 = val[7:0];  end
      2: begin in_valid2 = v; bin2 = val[15:0]; end
      default: begin in_valid3 = v; bin3 = val[0:0]; end
    endcase
  endtask

  function automatic logic f_valid(input int sel);
    case (sel)
      0: return out_valid0;
      1: return out_valid1;
      2: return out_valid2;
      default: return out_valid3;
    endcase
  endfunction

  function automatic logic f_ready(input int sel);
    case (sel)
      0: return in_ready0;
      1: return in_ready1;
      2: return in_ready2;
      default: return in_ready3;
    endcase
  endfunction

  function automatic logic [31:0] f_bcd(input int sel);
    case (sel)
      0: return {20'd0, bcd0};
      1: return {24'd0, bcd1};
      2: return {12'd0, bcd2};
      default: return {28'd0, bcd3};
    endcase
  endfunction

  function automatic logic f_ovf(input int sel);
    case (sel)
      0: return ovf0;
      1: return ovf1;
      2: return ovf2;
      default: return ovf3;
    endcase
  endfunction

  // One conversion with out_ready held high; lat counts edges from the accept edge.
  task automatic convert(input int sel, input logic [31:0] val, input logic [31:0] exp_bcd,
                         input logic exp_ovf, input int exp_lat, input string tag);
    int  lat;
    bit  seen;
    @(negedge clk);
    check({tag, "_rdy_idle"}, {31'd0, f_ready(sel)}, 32'd1);
    drive(sel, 1'b1, val);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        drive(sel, 1'b0, val);
        check({tag, "_rdy_busy"}, {31'd0, f_ready(sel)}, 32'd0);
      end
      if (f_valid(sel)) seen = 1'b1;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_bcd"}, f_bcd(sel), exp_bcd);
    check({tag, "_ovf"}, {31'd0, f_ovf(sel)}, {31'd0, exp_ovf});
    @(posedge clk);
    #1;
    check({tag, "_vld_drop"}, {31'd0, f_valid(sel)}, 32'd0);
  endtask

  initial begin
    int  n;
    int  vcount;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0); drive(3, 1'b0, 0);
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;

    #1;
    check("rst_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_bcd",   {20'd0, bcd0}, 32'h000);
    check("rst_ovf",   {31'd0, ovf0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, in_ready0}, 32'd1);
    check("min_digits8",  min_digits(8), 3);
    check("min_digits16", min_digits(16), 5);

    // 8 bits, 3 digits, back-to-back
    convert(0, 255, 32'h255, 1'b0, 9, "d3_255");
    convert(0, 0,   32'h000, 1'b0, 9, "d3_0");
    convert(0, 99,  32'h099, 1'b0, 9, "d3_99");
    convert(0, 100, 32'h100, 1'b0, 9, "d3_100");
    convert(0, 128, 32'h128, 1'b0, 9, "d3_128");
    convert(0, 1,   32'h001, 1'b0, 9, "d3_1");

    // 8 bits, 2 digits: result modulo 100 plus overflow
    convert(1, 100, 32'h00, 1'b1, 9, "d2_100");
    convert(1, 255, 32'h55, 1'b1, 9, "d2_255");
    convert(1, 99,  32'h99, 1'b0, 9, "d2_99");

    // 16 bits, 5 digits
    convert(2, 65535, 32'h65535, 1'b0, 17, "w16_65535");
    convert(2, 40000, 32'h40000, 1'b0, 17, "w16_40000");

    // 1 bit, 1 digit: single SHIFT cycle
    convert(3, 1, 32'h1, 1'b0, 2, "w1_1");
    convert(3, 0, 32'h0, 1'b0, 2, "w1_0");

    // Backpressure: result must hold while out_ready is low; held input waits
    @(negedge clk);
    out_ready0 = 1'b0;
    drive(0, 1'b1, 123);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 123);
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_lat", n, 8);
    drive(0, 1'b1, 45);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_vld", {31'd0, out_valid0}, 32'd1);
      check("bp_hold_bcd", {20'd0, bcd0}, 32'h123);
      check("bp_hold_rdy", {31'd0, in_ready0}, 32'd0);
    end
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_vld", {31'd0, out_valid0}, 32'd0);
    check("bp_release_rdy", {31'd0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_second_acc", {31'd0, in_ready0}, 32'd0);
    drive(0, 1'b0, 45);
    n = 0;
    while (!out_valid0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_second_lat", n, 8);
    check("bp_second_bcd", {20'd0, bcd0}, 32'h045);
    @(posedge clk);
    #1;

    // out_ready toggling while idle has no effect
    out_ready0 = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ordy_rdy", {31'd0, in_ready0}, 32'd1);
    check("idle_ordy_vld", {31'd0, out_valid0}, 32'd0);
    out_ready0 = 1'b1;

    // Reset mid-SHIFT after three shifts
    @(negedge clk);
    drive(0, 1'b1, 200);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 200);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, out_valid0}, 32'd0);
    check("mid_rst_bcd", {20'd0, bcd0}, 32'h000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_rdy", {31'd0, in_ready0}, 32'd1);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid0) vcount++;
    end
    check("mid_rst_no_vld", vcount, 0);
    convert(0, 37, 32'h037, 1'b0, 9, "post_rst_37");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
